// File: rtl/demux_1x4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_1x4_stream_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [NUM_CH-1:0] ch_mask_t;
  typedef logic [SEL_W-1:0]  ch_sel_t;

  // Write mask used when a word goes to every channel at once.
  localparam ch_mask_t BCAST_MASK = 4'b1111;

endpackage

// File: rtl/demux_1x4_stream_if.sv
// Producer-side input stream plus the four per-channel output handshakes.
interface demux_1x4_stream_if
  import demux_1x4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]        in_data;
  ch_sel_t                 in_sel;
  logic                    in_bcast;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  ch_mask_t                out_valid;
  ch_mask_t                out_ready;

  // Environment view: drives the producer side and the consumer readies.
  modport master (
    output in_data,
    output in_sel,
    output in_bcast,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  // Demultiplexer view.
  modport slave (
    input  in_data,
    input  in_sel,
    input  in_bcast,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/demux_1x4_stream_decoder_2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2to4
  import demux_1x4_stream_pkg::*;
(
  input  ch_sel_t  sel,
  input  logic     en,
  output ch_mask_t onehot
);

  // Decode the select into a single-bit mask, gated by the enable.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with per-channel handshakes and broadcast.
module demux_1x4_stream
  import demux_1x4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1x4_stream_if.slave     bus
);

  ch_mask_t full;
  ch_mask_t can_acc;
  ch_mask_t dec_onehot;
  ch_mask_t wr_en;
  logic     in_ready;
  logic     xfer;
  logic     dec_en;

  // A channel can take a word if it is empty or is being drained this cycle.
  always_comb begin
    can_acc = ~full | bus.out_ready;
  end

  // Broadcast needs every channel free so a broadcast is never partial.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bus.in_bcast) begin
        in_ready = &can_acc;
      end else begin
        in_ready = can_acc[bus.in_sel];
      end
    end
  end

  assign xfer   = bus.in_valid & in_ready;
  assign dec_en = xfer & ~bus.in_bcast;

  decoder_2to4 u_dec (
    .sel    (bus.in_sel),
    .en     (dec_en),
    .onehot (dec_onehot)
  );

  // Unicast uses the decoder; an accepted broadcast writes every channel.
  always_comb begin
    wr_en = dec_onehot;
    if (xfer && bus.in_bcast) begin
      wr_en = dec_onehot | BCAST_MASK;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // Load wins over drain so a full channel can stream one word per cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else if (wr_en[k]) begin
        full_q <= 1'b1;
        data_q <= bus.in_data;
      end else if (full_q && bus.out_ready[k]) begin
        full_q <= 1'b0;
      end
    end

    assign full[k]                          = full_q;
    assign bus.out_valid[k]                 = full_q;
    assign bus.out_data[k*WIDTH +: WIDTH]   = data_q;
  end

  assign bus.in_ready = in_ready;

endmodule
